obi_rom_pipelined: RTL and testbench
====================================

Name: obi_rom_pipelined

Overview:
- Parametrised read-only memory subordinate on the user-domain OBI bus.
- Contents come from a packed parameter. Used for ID strings such as "AB&CD's ASIC\0" and small constant tables.
- Read latency is configurable from 1 to 8 cycles. The block is fully pipelined, so it accepts one request per cycle with multiple reads in flight.
- Writes and accesses outside the populated range return an OBI error.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig: OBI configuration. Sets AddrWidth, DataWidth (must be 32) and IdWidth.
- obi_req_t, logic: OBI request struct type.
- obi_rsp_t, logic: OBI response struct type.
- NumWords, 8: number of populated 32-bit words, from 1 to 64. The default gives a 32-character capacity.
- InitData, all zeros (width NumWords*32): ROM contents. Word i is InitData[i*32 +: 32]. Byte 0 of a word is the lowest-addressed character, so ASCII strings are little-endian.
- Latency, 2: cycles from request handshake to rvalid, from 1 to 8.
- RegionBits, 8: number of low address bits decoded. Upper address bits are ignored; the interconnect has already selected this block. Must be at least clog2(NumWords)+2.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset. Asynchronous, active-low.
- obi_req_i  input  obi_req_t  OBI request: req, a.addr, a.we, a.be, a.wdata, a.aid.
- obi_rsp_o  output  obi_rsp_t  OBI response: gnt, rvalid, r.rdata, r.rid, r.err, r.r_optional.

Behaviour:
- Grant
  - gnt = obi_req_i.req, combinationally. Every request is accepted in the cycle it is presented; the block never stalls.
- Request pipeline
  - The pipeline has Latency stages. Each stage holds valid, we, word index, out-of-range flag and aid.
  - Stage 0 captures the request when req and gnt are both high. All stages shift every cycle.
  - rvalid is the valid bit of the last stage. rvalid therefore rises exactly Latency cycles after the handshake cycle.
  - N back-to-back requests produce N consecutive rvalid cycles, in order, with matching rid.
- Decode, done at capture time
  - offset = addr[RegionBits-1:0].
  - idx = offset[RegionBits-1:2].
  - oor = (idx >= NumWords).
  - addr[1:0] and be are ignored: a full aligned word is always returned.
- Read data
  - rdata is a registered table lookup, or a lookup applied at the final stage. Either choice is allowed as long as the total latency equals Latency.
  - rdata = InitData word idx when we=0 and oor=0; otherwise rdata = 0.
- Errors
  - err = 1 when we=1 or oor=1, reported in the response slot for that request.
  - A write never changes the contents.
- Output gating
  - When rvalid=0, rdata, rid and err must be 0. This keeps traces readable and makes checks deterministic.
  - r_optional is always 0.
- Reset values
  - All pipeline stages are cleared, so gnt follows req and rvalid=0, rdata=0, rid=0, err=0.
- Reset mid-operation
  - Asserting rst_ni low drops all in-flight requests. No rvalid is produced for them after reset is released.
  - The first request after release sees the full Latency.
- Latency=1 case
  - Behaves as a single-cycle registered ROM: rvalid in the cycle after the handshake.
- Simultaneous events
  - A new request captured in the same cycle an older response is output is independent of it. There are no hazards because the memory is read-only.
- Elaboration
  - Parameter checks are assertions guarded out of synthesis: Latency between 1 and 8, NumWords between 1 and 64, DataWidth == 32, and RegionBits >= clog2(NumWords)+2.

Test Plan:
1. Reset and idle, with NumWords=8 and Latency=2: hold rst_ni low, then release with req=0 -> rvalid=0, rdata=0, err=0 on every cycle.
2. Single read, with InitData word 1 = 32'h2764_4326 ("&Cd'"): req=1, addr=0x...04, aid=3 in cycle t -> gnt=1 at t; rvalid=1 at t+2 with rdata=32'h27644326, rid=3, err=0; rvalid=0 at t+1 and t+3.
3. Back-to-back burst: addresses 0x00, 0x04, 0x08, 0x1C with aids 0 to 3 in consecutive cycles, then repeat with Latency=1 and Latency=5 -> four consecutive rvalid cycles starting at t+Latency, data equal to words 0, 1, 2 and 7, rid 0 to 3 in order.
4. Errors: a write to 0x04 with wdata=32'hFFFFFFFF -> err=1, rdata=0. A subsequent read of 0x04 -> original word, err=0. A read of 0x20 (idx 8, out of range) -> err=1, rdata=0. A read of 0x105 (RegionBits=8) -> aliases to idx 1, returns word 1.
5. Reset mid-operation: issue reads in cycles t and t+1, pull rst_ni low asynchronously at t+1.5, release at t+3 -> no rvalid at any time afterwards. A new read at t+4 -> rvalid at t+6.
6. Random back-to-back reads and writes against a scoreboard for 10k cycles -> every accepted request gets exactly one response, in order, after exactly Latency cycles, with correct data, err and rid.

Source files
------------

// File: rtl/obi_rom_pipelined.sv
// Pipelined read-only OBI subordinate.
// Every request is granted in the cycle it is presented. The response comes
// out a fixed Latency cycles later, so several reads can be in flight at once.
// Writes and reads past the populated words return an error with zero data.

package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
        logic        r_optional;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

endpackage

module obi_rom_pipelined #(
    parameter obi_pkg::obi_cfg_t ObiCfg     = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t  = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t  = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumWords   = 8,
    parameter logic [NumWords*32-1:0] InitData = '0,
    parameter int unsigned       Latency    = 2,
    parameter int unsigned       RegionBits = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t obi_req_i,
    output obi_rsp_t obi_rsp_o
);

    localparam int unsigned IdW      = ObiCfg.IdWidth;
    // Width of the decoded word index; at least one bit so nothing is zero-width.
    localparam int unsigned IdxW     = (RegionBits > 2) ? RegionBits - 2 : 1;
    localparam int unsigned IdxExtW  = IdxW + 1;
    // Width needed to address the populated words; never wider than IdxW.
    localparam int unsigned WordW    = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int unsigned RomDepth = 1 << WordW;

    // Lookup table padded to a power of two so the final read never indexes past the end.
    logic [31:0] rom_words [RomDepth];

    for (genvar gi = 0; gi < RomDepth; gi++) begin : g_rom
        if (gi < NumWords) begin : g_pop
            assign rom_words[gi] = InitData[gi*32 +: 32];
        end else begin : g_pad
            assign rom_words[gi] = 32'h0;
        end
    end

    logic               handshake;
    logic [IdxW-1:0]    req_idx;
    logic               req_oor;
    logic [IdW-1:0]     req_aid;

    assign handshake = obi_req_i.req;
    assign req_aid   = IdW'(obi_req_i.a.aid);

    // The word index comes from the decoded region only; upper address bits alias.
    if (RegionBits > 2) begin : g_idx
        assign req_idx = obi_req_i.a.addr[RegionBits-1:2];
    end else begin : g_idx_none
        assign req_idx = '0;
    end

    // The comparison is one bit wider so NumWords == 2**IdxW does not wrap to zero.
    assign req_oor = ({1'b0, req_idx} >= IdxExtW'(NumWords));

    // Byte enables, write data, sub-word offset and upper address bits are ignored.
    logic unused_req_bits;
    assign unused_req_bits = ^{obi_req_i.a.be, obi_req_i.a.wdata, obi_req_i.a.addr, req_idx};

    logic [Latency-1:0] valid_q;
    logic [Latency-1:0] we_q;
    logic [Latency-1:0] oor_q;
    logic [WordW-1:0]   idx_q [Latency];
    logic [IdW-1:0]     aid_q [Latency];

    // Request pipeline: stage 0 captures the handshake and every stage shifts each cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            we_q    <= '0;
            oor_q   <= '0;
            for (int i = 0; i < Latency; i++) begin
                idx_q[i] <= '0;
                aid_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= handshake;
            we_q[0]    <= handshake & obi_req_i.a.we;
            oor_q[0]   <= handshake & req_oor;
            idx_q[0]   <= handshake ? req_idx[WordW-1:0] : '0;
            aid_q[0]   <= handshake ? req_aid : '0;
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                we_q[i]    <= we_q[i-1];
                oor_q[i]   <= oor_q[i-1];
                idx_q[i]   <= idx_q[i-1];
                aid_q[i]   <= aid_q[i-1];
            end
        end
    end

    logic           rsp_valid;
    logic           rsp_err;
    logic [31:0]    rsp_rdata;
    logic [IdW-1:0] rsp_rid;

    assign rsp_valid = valid_q[Latency-1];
    assign rsp_err   = rsp_valid & (we_q[Latency-1] | oor_q[Latency-1]);

    // Table lookup on the last stage; data and id are forced to zero whenever there is no valid read.
    always_comb begin
        rsp_rdata = 32'h0;
        rsp_rid   = '0;
        if (rsp_valid) begin
            rsp_rid = aid_q[Latency-1];
            if (!we_q[Latency-1] && !oor_q[Latency-1]) begin
                rsp_rdata = rom_words[idx_q[Latency-1]];
            end
        end
    end

    // Assemble the response; the grant simply mirrors the request.
    always_comb begin
        obi_rsp_o              = '0;
        obi_rsp_o.gnt          = obi_req_i.req;
        obi_rsp_o.rvalid       = rsp_valid;
        obi_rsp_o.r.rdata      = rsp_rdata;
        obi_rsp_o.r.rid        = rsp_rid;
        obi_rsp_o.r.err        = rsp_err;
        obi_rsp_o.r.r_optional = 1'b0;
    end

`ifndef SYNTHESIS
    // Sanity checks on the parameter set, kept out of the synthesised netlist.
    always @(posedge clk_i) begin
        assert (Latency >= 1 && Latency <= 8)
            else $error("obi_rom_pipelined: Latency must be 1..8");
        assert (NumWords >= 1 && NumWords <= 64)
            else $error("obi_rom_pipelined: NumWords must be 1..64");
        assert (ObiCfg.DataWidth == 32)
            else $error("obi_rom_pipelined: DataWidth must be 32");
        assert (RegionBits >= WordW + 2 && RegionBits <= ObiCfg.AddrWidth)
            else $error("obi_rom_pipelined: RegionBits too small for NumWords");
    end
`endif

endmodule

// File: tb/tb_obi_rom_pipelined.sv
// Testbench for obi_rom_pipelined: three instances (Latency 1, 2 and 5) share
// one request stream. A scoreboard queue holds the expected responses and a
// negedge monitor checks each instance against it independently.

module tb_obi_rom_pipelined;

    localparam logic [31:0] ROM_WORDS [8] = '{
        32'hA5A5_0001, 32'h2764_4326, 32'h4349_5341, 32'hDEAD_BEEF,
        32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321, 32'hCAFE_BABE
    };
    localparam logic [255:0] ROM_INIT = {
        32'hCAFE_BABE, 32'h8765_4321, 32'h1234_5678, 32'h0BAD_F00D,
        32'hDEAD_BEEF, 32'h4349_5341, 32'h2764_4326, 32'hA5A5_0001
    };

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rid;
        logic        err;
        int          issue;
    } exp_t;

    logic              clk;
    logic              rst_n;
    obi_pkg::obi_req_t req;
    obi_pkg::obi_rsp_t rsp [3];

    exp_t exp_q [$];
    int   head [3];
    int   lat [3] = '{1, 2, 5};
    int   neg_cnt;
    int   checks;
    int   failures;

    obi_rom_pipelined #(.NumWords(8), .InitData(ROM_INIT), .Latency(1), .RegionBits(8)) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_rsp_o(rsp[0])
    );
    obi_rom_pipelined #(.NumWords(8), .InitData(ROM_INIT), .Latency(2), .RegionBits(8)) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_rsp_o(rsp[1])
    );
    obi_rom_pipelined #(.NumWords(8), .InitData(ROM_INIT), .Latency(5), .RegionBits(8)) u_dut_l5 (
        .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_rsp_o(rsp[2])
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one request for one cycle and record its expected response.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] aid, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        req.req     = 1'b1;
        req.a.we    = we;
        req.a.addr  = addr;
        req.a.be    = 4'hF;
        req.a.wdata = wdata;
        req.a.aid   = aid;
        e.data  = exp_data;
        e.rid   = aid;
        e.err   = exp_err;
        e.issue = neg_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        req = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare one instance's outputs against the scoreboard.
    task automatic check_output(input int d);
        obi_pkg::obi_rsp_t r;
        exp_t e;
        r = rsp[d];
        checks++;
        if (r.gnt !== req.req) begin
            failures++;
            $display("[TB] FAIL gnt L=%0d: got %b want %b", lat[d], r.gnt, req.req);
        end
        checks++;
        if (r.r.r_optional !== 1'b0) begin
            failures++;
            $display("[TB] FAIL r_optional L=%0d: got %b want 0", lat[d], r.r.r_optional);
        end
        if (r.rvalid === 1'b1) begin
            checks++;
            if (head[d] >= exp_q.size()) begin
                failures++;
                $display("[TB] FAIL unexpected_rvalid L=%0d: got rvalid=1 want 0 (cycle %0d)", lat[d], neg_cnt);
            end else begin
                e = exp_q[head[d]];
                head[d]++;
                if (neg_cnt != e.issue + lat[d] + 1) begin
                    failures++;
                    $display("[TB] FAIL latency L=%0d: got cycle %0d want %0d", lat[d], neg_cnt, e.issue + lat[d] + 1);
                end
                checks++;
                if (r.r.rdata !== e.data) begin
                    failures++;
                    $display("[TB] FAIL rdata L=%0d: got %h want %h", lat[d], r.r.rdata, e.data);
                end
                checks++;
                if (r.r.rid !== e.rid) begin
                    failures++;
                    $display("[TB] FAIL rid L=%0d: got %0d want %0d", lat[d], r.r.rid, e.rid);
                end
                checks++;
                if (r.r.err !== e.err) begin
                    failures++;
                    $display("[TB] FAIL err L=%0d: got %b want %b", lat[d], r.r.err, e.err);
                end
            end
        end else begin
            checks++;
            if (r.rvalid !== 1'b0 || r.r.rdata !== 32'h0 || r.r.rid !== 4'h0 || r.r.err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_gating L=%0d: got rvalid=%b rdata=%h rid=%0d err=%b want all 0",
                         lat[d], r.rvalid, r.r.rdata, r.r.rid, r.r.err);
            end
            if (head[d] < exp_q.size() && exp_q[head[d]].issue + lat[d] + 1 <= neg_cnt) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_rvalid L=%0d: got rvalid=0 want 1 rid=%0d", lat[d], exp_q[head[d]].rid);
                head[d]++;
            end
        end
    endtask

    // Monitor: sample all instances on every falling edge.
    initial begin
        neg_cnt = 0;
        forever begin
            @(negedge clk);
            neg_cnt++;
            for (int d = 0; d < 3; d++) begin
                check_output(d);
            end
        end
    end

    // Reference model used for the randomised traffic.
    function automatic logic [31:0] model_data(input logic we, input logic [31:0] addr);
        logic [5:0] idx;
        idx = addr[7:2];
        if (we || idx >= 6'd8) return 32'h0;
        return ROM_WORDS[idx[2:0]];
    endfunction

    // Directed and randomised stimulus.
    initial begin
        logic        rw;
        logic [31:0] ra;
        logic        rerr;
        checks   = 0;
        failures = 0;
        head     = '{0, 0, 0};
        rst_n    = 1'b0;
        req      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset.
        idle_cycles(4);

        // Single read of word 1.
        apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'd3, 32'h2764_4326, 1'b0);
        idle_cycles(8);

        // Back-to-back burst.
        apply_stimulus(1'b0, 32'h0000_0000, 32'h0, 4'd0, 32'hA5A5_0001, 1'b0);
        apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'd1, 32'h2764_4326, 1'b0);
        apply_stimulus(1'b0, 32'h0000_0008, 32'h0, 4'd2, 32'h4349_5341, 1'b0);
        apply_stimulus(1'b0, 32'h0000_001C, 32'h0, 4'd3, 32'hCAFE_BABE, 1'b0);
        idle_cycles(8);

        // Errors, write protection and address aliasing.
        apply_stimulus(1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 4'd5, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h0000_0004, 32'h0, 4'd6, 32'h2764_4326, 1'b0);
        apply_stimulus(1'b0, 32'h0000_0020, 32'h0, 4'd7, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h0000_0105, 32'h0, 4'd8, 32'h2764_4326, 1'b0);
        apply_stimulus(1'b0, 32'h0000_00FC, 32'h0, 4'd9, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'hFFFF_FF14, 32'h0, 4'd10, 32'h1234_5678, 1'b0);
        idle_cycles(8);

        // Reset in the middle of a pair of reads.
        apply_stimulus(1'b0, 32'h0000_000C, 32'h0, 4'd11, 32'hDEAD_BEEF, 1'b0);
        req.a.addr = 32'h0000_0010;
        req.a.aid  = 4'd12;
        #5;
        rst_n = 1'b0;
        exp_q.delete();
        head = '{0, 0, 0};
        @(posedge clk);
        #1;
        req = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(1);
        apply_stimulus(1'b0, 32'h0000_0018, 32'h0, 4'd13, 32'h8765_4321, 1'b0);
        idle_cycles(8);

        // Randomised reads and writes, including idle gaps.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) begin
                idle_cycles(1);
            end else begin
                rw   = ($urandom_range(3) == 0);
                ra   = 32'($urandom_range(1023));
                rerr = rw || (ra[7:2] >= 6'd8);
                apply_stimulus(rw, ra, $urandom, 4'($urandom_range(15)), model_data(rw, ra), rerr);
            end
        end
        idle_cycles(12);

        // Every recorded request must have produced its response.
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (head[d] != exp_q.size()) begin
                failures++;
                $display("[TB] FAIL drain L=%0d: got %0d responses want %0d", lat[d], head[d], exp_q.size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
